// File: rtl/pru1_mem_loader.sv
`timescale 1ns/1ps
// Byte-stream image loader for the 1024x32 single-port RAM: packs little-endian words, writes, then re-reads and checks byte sums.
// Latency: done pulses 2 + N_words cycles after the final write; s_ready is low outside LOAD (one byte per cycle max).
module pru1_mem_loader #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              err_wrap,
  output logic [CNT_W-1:0]  byte_count,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [1:0]        lane;
  logic [3:0]        be_pack;
  logic [3:0]        last_be;
  logic              last_seen;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  rd_idx;
  logic [15:0]       rd_sum;

  function automatic logic [15:0] byte_sum(input logic [31:0] d, input logic [3:0] be);
    logic [15:0] s;
    s = 16'd0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) s = s + {8'd0, d[8*i +: 8]};
    end
    return s;
  endfunction

  assign clken = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      lane       <= 2'd0;
      be_pack    <= 4'd0;
      last_be    <= 4'd0;
      last_seen  <= 1'b0;
      word_cnt   <= '0;
      rd_idx     <= '0;
      rd_sum     <= 16'd0;
      s_ready    <= 1'b0;
      address    <= '0;
      byteenable <= 4'd0;
      chipselect <= 1'b0;
      write      <= 1'b0;
      writedata  <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      match      <= 1'b0;
      err_wrap   <= 1'b0;
      byte_count <= '0;
      checksum   <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            base_q     <= base_addr;
            address    <= base_addr;
            byte_count <= '0;
            checksum   <= 16'd0;
            rd_sum     <= 16'd0;
            err_wrap   <= 1'b0;
            match      <= 1'b0;
            lane       <= 2'd0;
            be_pack    <= 4'd0;
            writedata  <= 32'd0;
            word_cnt   <= '0;
            busy       <= 1'b1;
            s_ready    <= 1'b1;
          end
        end
        LOAD: begin
          if (s_valid) begin
            writedata[8*lane +: 8] <= s_data;
            be_pack[lane]          <= 1'b1;
            checksum               <= checksum + {8'd0, s_data};
            lane                   <= lane + 2'd1;
            if (byte_count != '1) byte_count <= byte_count + CNT_W'(1);
            if (lane == 2'd3 || s_last) begin
              state      <= WRITE;
              last_seen  <= s_last;
              s_ready    <= 1'b0;
              chipselect <= 1'b1;
              write      <= 1'b1;
              byteenable <= be_pack | (4'b0001 << lane);
            end
          end
        end
        WRITE: begin
          address   <= address + ADDR_W'(1);
          word_cnt  <= word_cnt + CNT_W'(1);
          last_be   <= byteenable;
          writedata <= 32'd0;
          be_pack   <= 4'd0;
          lane      <= 2'd0;
          if (address == '1) err_wrap <= 1'b1;
          if (last_seen) begin
            // Verify re-reads the whole region from the latched start address.
            state      <= VERIFY;
            address    <= base_q;
            write      <= 1'b0;
            byteenable <= 4'hF;
            rd_idx     <= '0;
          end else begin
            state      <= LOAD;
            chipselect <= 1'b0;
            write      <= 1'b0;
            byteenable <= 4'd0;
            s_ready    <= 1'b1;
          end
        end
        VERIFY: begin
          // Data for read k arrives during cycle k+1; the last word lands in DRAIN.
          if (rd_idx != '0) rd_sum <= rd_sum + byte_sum(readdata, 4'hF);
          if (rd_idx == word_cnt - CNT_W'(1)) begin
            state      <= DRAIN;
            chipselect <= 1'b0;
            byteenable <= 4'd0;
          end else begin
            address <= address + ADDR_W'(1);
            rd_idx  <= rd_idx + CNT_W'(1);
          end
        end
        DRAIN: begin
          match <= ((rd_sum + byte_sum(readdata, last_be)) == checksum);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pru1_mem_loader.sv
`timescale 1ns/1ps
// Bench for pru1_mem_loader: memory model with optional read corruption, table vectors, random images, reset mid-verify.
module tb_pru1_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [9:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic [31:0] readdata = 32'd0;
  logic        busy;
  logic        done;
  logic        match;
  logic        err_wrap;
  logic [12:0] byte_count;
  logic [15:0] checksum;

  always #5 clk = ~clk;

  pru1_mem_loader #(.ADDR_W(10), .CNT_W(13)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .clken(clken), .readdata(readdata),
    .busy(busy), .done(done), .match(match), .err_wrap(err_wrap),
    .byte_count(byte_count), .checksum(checksum)
  );

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Single-port RAM model, 1-cycle read latency, optional corruption of one word on readback.
  logic [31:0] mem [1024];
  bit          corrupt_en = 1'b0;
  logic [9:0]  corrupt_addr = 10'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (chipselect && clken) begin
      if (write) begin
        for (int i = 0; i < 4; i++)
          if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
      end else begin
        readdata <= mem[address] ^ ((corrupt_en && address == corrupt_addr) ? 32'h000000FF : 32'h0);
      end
    end
  end

  typedef struct { logic [9:0] a; logic [3:0] be; logic [31:0] d; int c; } wr_t;
  wr_t        wr_log[$];
  logic [9:0] rd_log[$];

  always @(negedge clk) begin
    if (!reset && chipselect) begin
      if (write) begin
        wr_log.push_back('{address, byteenable, writedata, cyc});
        chk("s_ready_in_write", {31'd0, s_ready}, 32'd0);
      end else begin
        rd_log.push_back(address);
        chk("read_byteenable", {28'd0, byteenable}, 32'hF);
      end
    end
  end

  logic [7:0] img[$];
  int         done_cyc;

  task automatic run_load(input logic [9:0] base, input int vpct, input bit poke);
    int idx;
    int guard;
    bit seen;
    wr_log.delete();
    rd_log.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < img.size() && guard < 5000) begin
      s_valid = ($urandom_range(99) < vpct);
      s_data  = img[idx];
      s_last  = (idx == img.size() - 1);
      start   = poke && (idx == img.size() / 2);
      base_addr = ~base;
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
    chk("stream_accepted", idx, img.size());
    seen = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; done_cyc = cyc; end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  // Reference: image -> expected word sequence, sums and flags from the stated rules.
  task automatic check_model(input logic [9:0] base);
    int          n, nw, nwr, nrd;
    logic [15:0] cks;
    logic [31:0] d;
    logic [3:0]  be;
    logic [9:0]  off;
    bit          hit, wrap;
    n   = img.size();
    nw  = (n + 3) / 4;
    cks = 16'd0;
    foreach (img[k]) cks = cks + {8'd0, img[k]};
    off  = corrupt_addr - base;
    hit  = corrupt_en && (int'(off) < nw);
    wrap = (int'(base) + nw >= 1024);
    chk("match", {31'd0, match}, {31'd0, !hit});
    chk("err_wrap", {31'd0, err_wrap}, {31'd0, wrap});
    chk("checksum", {16'd0, checksum}, {16'd0, cks});
    chk("byte_count", {19'd0, byte_count}, n);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("n_writes", wr_log.size(), nw);
    nwr = (wr_log.size() < nw) ? wr_log.size() : nw;
    for (int i = 0; i < nwr; i++) begin
      d = 32'd0; be = 4'd0;
      for (int j = 0; j < 4; j++)
        if (4*i + j < n) begin d[8*j +: 8] = img[4*i + j]; be[j] = 1'b1; end
      chk("wr_addr", {22'd0, wr_log[i].a}, {22'd0, base + 10'(i)});
      chk("wr_data", wr_log[i].d, d);
      chk("wr_be", {28'd0, wr_log[i].be}, {28'd0, be});
    end
    chk("n_reads", rd_log.size(), nw);
    nrd = (rd_log.size() < nw) ? rd_log.size() : nw;
    for (int i = 0; i < nrd; i++)
      chk("rd_addr", {22'd0, rd_log[i]}, {22'd0, base + 10'(i)});
    if (wr_log.size() > 0) chk("done_latency", done_cyc - wr_log[wr_log.size()-1].c, nw + 2);
  endtask

  typedef struct {
    logic [9:0]  base;
    int          n;
    logic [63:0] b;
    bit          cor;
    logic [9:0]  caddr;
    logic [15:0] cks;
    bit          m;
    bit          w;
    logic [9:0]  la;
    logic [31:0] lw;
    logic [3:0]  lbe;
  } vec_t;

  vec_t tv[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          seen;
    int          n;
    logic [9:0]  base;

    tv[0] = '{10'h010, 8, 64'h0807060504030201, 1'b0, 10'h000, 16'h0024, 1'b1, 1'b0, 10'h011, 32'h08070605, 4'hF};
    tv[1] = '{10'h010, 5, 64'h000000EEDDCCBBAA, 1'b0, 10'h000, 16'h03FC, 1'b1, 1'b0, 10'h011, 32'h000000EE, 4'h1};
    tv[2] = '{10'h010, 8, 64'h0807060504030201, 1'b1, 10'h011, 16'h0024, 1'b0, 1'b0, 10'h011, 32'h08070605, 4'hF};
    tv[3] = '{10'h3FF, 8, 64'h0807060504030201, 1'b0, 10'h000, 16'h0024, 1'b1, 1'b1, 10'h000, 32'h08070605, 4'hF};
    tv[4] = '{10'h100, 1, 64'h000000000000005A, 1'b0, 10'h000, 16'h005A, 1'b1, 1'b0, 10'h100, 32'h0000005A, 4'h1};

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    reset = 1'b1; start = 1'b0; base_addr = 10'd0;
    s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {s_ready, chipselect, write, clken, busy, done, match, err_wrap, byteenable},
        32'd0);
    chk("rst_counts", {address, byte_count, 9'd0}, 32'd0);
    chk("rst_data", writedata ^ {16'd0, checksum}, 32'd0);
    #1 reset = 1'b0;

    // Stream bytes offered with no start must not be taken.
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_s_ready", {31'd0, s_ready}, 32'd0);
    end
    chk("idle_byte_count", {19'd0, byte_count}, 32'd0);
    #1 s_valid = 1'b0; s_last = 1'b0;

    for (int t = 0; t < 5; t++) begin
      img.delete();
      for (int k = 0; k < tv[t].n; k++) img.push_back(tv[t].b[8*k +: 8]);
      corrupt_en = tv[t].cor; corrupt_addr = tv[t].caddr;
      run_load(tv[t].base, 100, 1'b0);
      chk("tv_checksum", {16'd0, checksum}, {16'd0, tv[t].cks});
      chk("tv_match", {31'd0, match}, {31'd0, tv[t].m});
      chk("tv_err_wrap", {31'd0, err_wrap}, {31'd0, tv[t].w});
      chk("tv_byte_count", {19'd0, byte_count}, tv[t].n);
      if (wr_log.size() > 0) begin
        chk("tv_last_addr", {22'd0, wr_log[wr_log.size()-1].a}, {22'd0, tv[t].la});
        chk("tv_last_data", wr_log[wr_log.size()-1].d, tv[t].lw);
        chk("tv_last_be", {28'd0, wr_log[wr_log.size()-1].be}, {28'd0, tv[t].lbe});
      end else begin
        chk("tv_no_writes", 32'd0, 32'd1);
      end
      check_model(tv[t].base);
    end

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(1, 40);
      base = ($urandom_range(3) == 0) ? 10'(1024 - $urandom_range(1, 8)) : 10'($urandom);
      img.delete();
      for (int k = 0; k < n; k++) img.push_back(8'($urandom));
      corrupt_en = ($urandom_range(2) == 0);
      corrupt_addr = base + 10'($urandom_range(0, (n + 3) / 4));
      run_load(base, $urandom_range(30, 100), 1'($urandom_range(1)));
      check_model(base);
    end

    // Reset while reads are in flight, then a clean load.
    corrupt_en = 1'b0;
    img.delete();
    for (int k = 0; k < 16; k++) img.push_back(8'(k * 3 + 1));
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h200;
    @(posedge clk); #1;
    start = 1'b0;
    s_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s_data = img[k]; s_last = (k == 15);
      @(posedge clk); #1;
      while (!(s_ready === 1'b0 || k == 15) && 0) @(posedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (chipselect && !write) seen = 1'b1;
    end
    chk("reached_verify", {31'd0, seen}, 32'd1);
    #2 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rv_chipselect", {31'd0, chipselect}, 32'd0);
    chk("rv_busy", {31'd0, busy}, 32'd0);
    chk("rv_outputs", {s_ready, write, clken, done, match, err_wrap, byteenable, address}, 32'd0);
    chk("rv_counts", {byte_count, checksum, 3'd0}, 32'd0);
    chk("rv_writedata", writedata, 32'd0);
    #1 reset = 1'b0;

    img.delete();
    for (int k = 0; k < tv[0].n; k++) img.push_back(tv[0].b[8*k +: 8]);
    run_load(10'h010, 60, 1'b1);
    chk("fresh_checksum", {16'd0, checksum}, 32'h0024);
    check_model(10'h010);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
